// File: rtl/pulse_syn_tx_if.sv
// rtl/pulse_syn_tx_if.sv - bus bundle for the source end of the toggle/ack pulse synchronizer
// Signals:
//   wr_pulse     source -> tx   event request, one event per high cycle
//   wr_clear_ovf source -> tx   clears the sticky overflow flag
//   rd_ack_tgl   dest   -> tx   acknowledge toggle, asynchronous to wr_clk
//   wr_req_tgl   tx     -> dest request toggle, registered
//   wr_busy      tx     -> src  a launched event awaits acknowledge
//   wr_sent      tx     -> src  one-cycle pulse on transfer completion
//   wr_pending   tx     -> src  events accepted but not yet launched
//   wr_overflow  tx     -> src  sticky, an event was dropped
// Modports: master = event source / destination side, slave = pulse_syn_tx.
interface pulse_syn_tx_if #(
  parameter int CNT_W = 4
);
  logic             wr_pulse;
  logic             wr_clear_ovf;
  logic             rd_ack_tgl;
  logic             wr_req_tgl;
  logic             wr_busy;
  logic             wr_sent;
  logic [CNT_W-1:0] wr_pending;
  logic             wr_overflow;

  modport master (
    output wr_pulse,
    output wr_clear_ovf,
    output rd_ack_tgl,
    input  wr_req_tgl,
    input  wr_busy,
    input  wr_sent,
    input  wr_pending,
    input  wr_overflow
  );

  modport slave (
    input  wr_pulse,
    input  wr_clear_ovf,
    input  rd_ack_tgl,
    output wr_req_tgl,
    output wr_busy,
    output wr_sent,
    output wr_pending,
    output wr_overflow
  );
endinterface

// File: rtl/pulse_syn_tx.sv
// rtl/pulse_syn_tx.sv - source-domain end of the toggle/ack pulse synchronizer
// Ports:
//   wr_clk    source-domain clock
//   wr_reset  synchronous active-high reset
//   bus       pulse_syn_tx_if.slave (wr_pulse, wr_clear_ovf, rd_ack_tgl in;
//             wr_req_tgl, wr_busy, wr_sent, wr_pending, wr_overflow out)
// Each event pulse becomes one inversion of wr_req_tgl; the next event is only
// launched once the destination's ack toggle, double-synchronized, matches the
// request. Events arriving meanwhile queue in a saturating pending counter.
module pulse_syn_tx #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input logic           wr_clk,
  input logic           wr_reset,
  pulse_syn_tx_if.slave bus
);
  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic                   req_q, req_d;
  logic                   sent_q, sent_d;
  logic                   ovf_q, ovf_d;
  logic [CNT_W-1:0]       pend_q, pend_d;
  logic                   backlog_nz;
  logic                   launch;
  logic                   launch_bl;
  logic                   done;
  logic                   to_backlog;
  logic                   drop;

  // rd_ack_tgl is only ever sampled by the first flop of this chain.
  always_ff @(posedge wr_clk) begin
    if (wr_reset) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], bus.rd_ack_tgl};
    end
  end

  assign ack_s      = ack_sync[SYNC_STAGES-1];
  assign backlog_nz = |pend_q;

  // State register plus the registered datapath it steers.
  always_ff @(posedge wr_clk) begin
    if (wr_reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      sent_q  <= 1'b0;
      ovf_q   <= 1'b0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      sent_q  <= sent_d;
      ovf_q   <= ovf_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state logic. An ack change seen in IDLE is a protocol error and is ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (backlog_nz || bus.wr_pulse) state_d = WAIT_ACK;
      WAIT_ACK: if (ack_s == req_q)             state_d = IDLE;
    endcase
  end

  // Output / datapath logic.
  always_comb begin
    launch     = (state_q == IDLE) && (backlog_nz || bus.wr_pulse);
    done       = (state_q == WAIT_ACK) && (ack_s == req_q);
    // With a backlog, the oldest queued event goes out and any same-edge pulse
    // joins the queue; with no backlog, the pulse itself is launched.
    launch_bl  = launch && backlog_nz;
    to_backlog = bus.wr_pulse && !(launch && !backlog_nz);
    // A pulse offset by a backlog launch never overflows, even when full.
    drop       = to_backlog && !launch_bl && (pend_q == CNT_MAX);

    req_d  = req_q ^ launch;
    sent_d = done;

    pend_d = pend_q;
    if (to_backlog && !launch_bl && !drop) begin
      pend_d = pend_q + 1'b1;
    end else if (launch_bl && !to_backlog) begin
      pend_d = pend_q - 1'b1;
    end

    // A drop on the same edge as a clear keeps the flag set.
    ovf_d = drop | (ovf_q & ~bus.wr_clear_ovf);
  end

  assign bus.wr_req_tgl  = req_q;
  assign bus.wr_busy     = (state_q == WAIT_ACK);
  assign bus.wr_sent     = sent_q;
  assign bus.wr_pending  = pend_q;
  assign bus.wr_overflow = ovf_q;
endmodule

// File: tb/tb_pulse_syn_tx.sv
// tb/tb_pulse_syn_tx.sv - self-checking bench for pulse_syn_tx
module tb_pulse_syn_tx;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 4;
  localparam int MAXP        = (1 << CNT_W) - 1;

  logic wr_clk = 1'b0;
  logic wr_reset;

  always #5 wr_clk = ~wr_clk;

  pulse_syn_tx_if #(.CNT_W(CNT_W)) bus ();

  pulse_syn_tx #(
    .SYNC_STAGES(SYNC_STAGES),
    .CNT_W      (CNT_W)
  ) dut (
    .wr_clk  (wr_clk),
    .wr_reset(wr_reset),
    .bus     (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: transfer-level view of the protocol.
  bit m_req, m_busy, m_sent, m_ovf;
  int m_backlog;
  bit ack_line[$];   // rd_ack_tgl as seen SYNC_STAGES edges later

  // Receiver emulation: echoes the request toggle back after ack_delay cycles.
  bit echo_en;
  int ack_delay;
  bit echo_q[$];

  function automatic void model_edge(input bit pulse, input bit clr, input bit rst, input bit ack_in);
    bit ack_seen;
    bit drop;
    if (rst) begin
      m_req = 0; m_busy = 0; m_sent = 0; m_ovf = 0; m_backlog = 0;
      ack_line.delete();
      for (int i = 0; i < SYNC_STAGES; i++) ack_line.push_back(1'b0);
      return;
    end
    ack_seen = ack_line.pop_front();
    ack_line.push_back(ack_in);
    drop   = 0;
    m_sent = 0;
    if (m_busy) begin
      if (ack_seen == m_req) begin
        m_busy = 0;
        m_sent = 1;
      end
      if (pulse) begin
        if (m_backlog < MAXP) m_backlog++;
        else drop = 1;
      end
    end else if (m_backlog > 0) begin
      m_req  = !m_req;
      m_busy = 1;
      if (!pulse) m_backlog--;
    end else if (pulse) begin
      m_req  = !m_req;
      m_busy = 1;
    end
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
  endfunction

  function automatic logic [CNT_W+3:0] exp_vec();
    return {m_req, m_busy, m_sent, m_ovf, m_backlog[CNT_W-1:0]};
  endfunction

  function automatic logic [CNT_W+3:0] act_vec();
    return {bus.wr_req_tgl, bus.wr_busy, bus.wr_sent, bus.wr_overflow, bus.wr_pending};
  endfunction

  // Drive one cycle of inputs, let the edge happen, advance the model, park at negedge.
  task automatic step(input bit pulse, input bit clr, input bit rst);
    if (rst) begin
      echo_q.delete();
      bus.rd_ack_tgl = 1'b0;
    end else if (echo_en) begin
      echo_q.push_back(bus.wr_req_tgl);
      if (echo_q.size() > ack_delay) bus.rd_ack_tgl = echo_q.pop_front();
    end
    wr_reset         = rst;
    bus.wr_pulse     = pulse;
    bus.wr_clear_ovf = clr;
    @(posedge wr_clk);
    model_edge(pulse, clr, rst, bus.rd_ack_tgl);
    @(negedge wr_clk);
    wr_reset         = 1'b0;
    bus.wr_pulse     = 1'b0;
    bus.wr_clear_ovf = 1'b0;
  endtask

  task automatic test_reset();
    echo_en = 0;
    bus.rd_ack_tgl = 1'b0;
    step(0, 0, 1);
    step(1, 1, 1);
    n_checks++;
    if (act_vec() !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required %b", act_vec(), {(CNT_W+4){1'b0}});
    end
    n_checks++;
    if (act_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_model: got %b required %b", act_vec(), exp_vec());
    end
  endtask

  task automatic test_single_event();
    int sent_cnt;
    step(0, 0, 1);
    echo_en = 1; ack_delay = 3;
    step(1, 0, 0);
    n_checks++;
    if ({bus.wr_req_tgl, bus.wr_busy, bus.wr_pending, bus.wr_overflow} !== {2'b11, {CNT_W{1'b0}}, 1'b0}) begin
      n_fail++;
      $display("FAIL single_launch: got req=%b busy=%b pend=%0d ovf=%b required req=1 busy=1 pend=0 ovf=0",
               bus.wr_req_tgl, bus.wr_busy, bus.wr_pending, bus.wr_overflow);
    end
    sent_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0);
      sent_cnt += int'(bus.wr_sent);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL single_cycle%0d: got %b required %b", i, act_vec(), exp_vec());
      end
    end
    n_checks++;
    if (sent_cnt != 1) begin
      n_fail++;
      $display("FAIL single_sent_count: got %0d required 1", sent_cnt);
    end
  endtask

  task automatic test_burst();
    int  max_p, toggles, sents;
    bit  prev_req, finished;
    step(0, 0, 1);
    echo_en = 1; ack_delay = 6;
    max_p = 0; toggles = 0; sents = 0; finished = 0;
    prev_req = bus.wr_req_tgl;
    for (int cyc = 0; cyc < 300; cyc++) begin
      step(cyc < 5, 0, 0);
      if (bus.wr_req_tgl !== prev_req) toggles++;
      prev_req = bus.wr_req_tgl;
      sents += int'(bus.wr_sent);
      if (int'(bus.wr_pending) > max_p) max_p = int'(bus.wr_pending);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL burst_cycle%0d: got %b required %b", cyc, act_vec(), exp_vec());
      end
      if (cyc >= 5 && !m_busy && m_backlog == 0) begin
        finished = 1;
        break;
      end
    end
    n_checks++;
    if (!finished) begin
      n_fail++;
      $display("FAIL burst_timeout: got busy=%b pend=%0d required drained within 300 cycles",
               bus.wr_busy, bus.wr_pending);
    end
    n_checks++;
    if (max_p != 4) begin
      n_fail++;
      $display("FAIL burst_max_pending: got %0d required 4", max_p);
    end
    n_checks++;
    if (toggles != 5) begin
      n_fail++;
      $display("FAIL burst_toggles: got %0d required 5", toggles);
    end
    n_checks++;
    if (sents != 5) begin
      n_fail++;
      $display("FAIL burst_sent_count: got %0d required 5", sents);
    end
    n_checks++;
    if (bus.wr_req_tgl !== 1'b1) begin
      n_fail++;
      $display("FAIL burst_final_req: got %b required 1", bus.wr_req_tgl);
    end
  endtask

  task automatic test_saturation();
    step(0, 0, 1);
    echo_en = 0;
    bus.rd_ack_tgl = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL sat_cycle%0d: got %b required %b", i, act_vec(), exp_vec());
      end
    end
    n_checks++;
    if ({bus.wr_pending, bus.wr_overflow} !== {4'd15, 1'b1}) begin
      n_fail++;
      $display("FAIL sat_full: got pend=%0d ovf=%b required pend=15 ovf=1", bus.wr_pending, bus.wr_overflow);
    end
    step(1, 1, 0);
    n_checks++;
    if (bus.wr_overflow !== 1'b1 || bus.wr_pending !== 4'd15) begin
      n_fail++;
      $display("FAIL sat_clear_on_drop: got ovf=%b pend=%0d required ovf=1 pend=15", bus.wr_overflow, bus.wr_pending);
    end
    step(0, 1, 0);
    n_checks++;
    if (bus.wr_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_clear: got ovf=%b required 0", bus.wr_overflow);
    end
    step(0, 0, 0);
    n_checks++;
    if (act_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL sat_after_clear: got %b required %b", act_vec(), exp_vec());
    end
  endtask

  task automatic test_simultaneous();
    bit prev_req, idle_seen;
    step(0, 0, 1);
    echo_en = 1; ack_delay = 4;
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    n_checks++;
    if (bus.wr_pending !== 4'd3) begin
      n_fail++;
      $display("FAIL simul_backlog: got %0d required 3", bus.wr_pending);
    end
    idle_seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (!m_busy) begin
        idle_seen = 1;
        break;
      end
      step(0, 0, 0);
    end
    n_checks++;
    if (!idle_seen) begin
      n_fail++;
      $display("FAIL simul_timeout: got busy=%b required idle within 100 cycles", bus.wr_busy);
    end
    prev_req = bus.wr_req_tgl;
    step(1, 0, 0);
    n_checks++;
    if ({bus.wr_pending, bus.wr_req_tgl, bus.wr_busy} !== {4'd3, !prev_req, 1'b1}) begin
      n_fail++;
      $display("FAIL simul_launch: got pend=%0d req=%b busy=%b required pend=3 req=%b busy=1",
               bus.wr_pending, bus.wr_req_tgl, bus.wr_busy, !prev_req);
    end
    n_checks++;
    if (act_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL simul_model: got %b required %b", act_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    step(0, 0, 1);
    echo_en = 0;
    bus.rd_ack_tgl = 1'b0;
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    n_checks++;
    if ({bus.wr_busy, bus.wr_pending} !== {1'b1, 4'd2}) begin
      n_fail++;
      $display("FAIL rstmid_setup: got busy=%b pend=%0d required busy=1 pend=2", bus.wr_busy, bus.wr_pending);
    end
    step(0, 0, 1);
    n_checks++;
    if (act_vec() !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got %b required all zero", act_vec());
    end
    echo_en = 1; ack_delay = 2;
    step(1, 0, 0);
    n_checks++;
    if ({bus.wr_req_tgl, bus.wr_busy, bus.wr_pending} !== {2'b11, 4'd0}) begin
      n_fail++;
      $display("FAIL rstmid_relaunch: got req=%b busy=%b pend=%0d required req=1 busy=1 pend=0",
               bus.wr_req_tgl, bus.wr_busy, bus.wr_pending);
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL rstmid_cycle%0d: got %b required %b", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_spurious_ack();
    step(0, 0, 1);
    echo_en = 0;
    bus.rd_ack_tgl = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) bus.rd_ack_tgl = 1'b0;
      step(0, 0, 0);
      n_checks++;
      if ({bus.wr_sent, bus.wr_busy, bus.wr_req_tgl} !== 3'b000) begin
        n_fail++;
        $display("FAIL spurious_cycle%0d: got sent=%b busy=%b req=%b required 0 0 0",
                 i, bus.wr_sent, bus.wr_busy, bus.wr_req_tgl);
      end
    end
  endtask

  task automatic test_random();
    int pulse_pct;
    step(0, 0, 1);
    echo_en   = 1;
    ack_delay = int'($urandom_range(10, 1));
    pulse_pct = int'($urandom_range(90, 20));
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if ($urandom_range(199, 0) == 0) begin
        ack_delay = int'($urandom_range(10, 1));
        pulse_pct = int'($urandom_range(90, 20));
        step(0, 0, 1);
      end else begin
        step($urandom_range(99, 0) < pulse_pct, $urandom_range(9, 0) == 0, 0);
      end
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got %b required %b", cyc, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    wr_reset         = 1'b1;
    bus.wr_pulse     = 1'b0;
    bus.wr_clear_ovf = 1'b0;
    bus.rd_ack_tgl   = 1'b0;
    echo_en          = 0;
    ack_delay        = 3;
    @(negedge wr_clk);
    test_reset();
    test_single_event();
    test_burst();
    test_saturation();
    test_simultaneous();
    test_reset_mid();
    test_spurious_ack();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running required completion before 1ms");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/pulse_syn_tx.md
Name: pulse_syn_tx

Overview:
- Source-domain (write-side) end of the toggle/ack pulse-synchronization protocol.
- Accepts single-cycle event pulses on wr_clk and converts each one into a level toggle on wr_req_tgl for the destination domain.
- Waits for the destination's returned acknowledge toggle, double-synchronized internally, before launching the next event.
- Events that arrive while a transfer is in flight are counted in a saturating pending counter, so back-to-back source pulses are never merged silently.

Parameters:
- SYNC_STAGES, 2, number of flops in the rd_ack_tgl synchronizer chain (legal values 2..4).
- CNT_W, 4, width of the pending-event counter; maximum backlog is 2^CNT_W-1 events.

Ports:
- wr_clk  input  1  source-domain clock.
- wr_reset  input  1  synchronous, active-high reset.
- wr_pulse  input  1  event request; each cycle it is high counts as one event.
- rd_ack_tgl  input  1  acknowledge toggle from the destination end; asynchronous to wr_clk.
- wr_clear_ovf  input  1  clears the sticky overflow flag.
- wr_req_tgl  output  1  request toggle to the destination end; registered, glitch-free.
- wr_busy  output  1  high while a launched event awaits acknowledge.
- wr_sent  output  1  one-cycle pulse when an acknowledge completes a transfer.
- wr_pending  output  CNT_W  events accepted but not yet launched.
- wr_overflow  output  1  sticky; an event was dropped because the counter was full.

Behaviour:
- Reset (wr_reset high at a wr_clk edge):
  - State returns to IDLE.
  - wr_req_tgl, every synchronizer flop, wr_busy, wr_sent and wr_overflow go to 0; wr_pending goes to 0.
  - Reset takes priority over all other inputs.
  - Reset mid-transfer discards the in-flight event and the backlog. The destination end must be reset in the same window so that both toggles restart at 0.
- Acknowledge synchronizer:
  - rd_ack_tgl passes through SYNC_STAGES flops; ack_s is the last stage.
  - No other logic samples rd_ack_tgl directly.
- FSM states: IDLE, WAIT_ACK.
  - IDLE, launch condition is wr_pending>0 or wr_pulse=1. On the launch edge:
    - wr_req_tgl inverts and state goes to WAIT_ACK.
    - If wr_pending>0, the launched event is taken from the backlog. A wr_pulse sampled on the same edge is added to the backlog, so the net count is unchanged.
    - If wr_pending==0, the wr_pulse itself is launched and the count stays 0.
  - WAIT_ACK: when ack_s==wr_req_tgl, state goes to IDLE and wr_sent=1 for exactly the following cycle. Otherwise the FSM stays in WAIT_ACK.
  - wr_busy is 1 exactly when state==WAIT_ACK (registered).
- Latency:
  - wr_pulse sampled at edge k in IDLE with an empty backlog: wr_req_tgl changes after edge k.
  - rd_ack_tgl changes before edge m (SYNC_STAGES=2): ack_s updates after edge m+1; IDLE and wr_sent=1 after edge m+2.
  - The earliest next launch is edge m+3. IDLE always lasts at least one cycle between transfers.
- Pending counter:
  - Increments on every wr_pulse that is not launched directly; decrements on a launch from backlog.
  - Saturates at 2^CNT_W-1. A wr_pulse arriving when full and not offset by a same-edge backlog launch is dropped and sets wr_overflow.
  - A pulse coinciding with a backlog launch while full is accepted; the count stays full.
- Overflow flag:
  - wr_clear_ovf clears wr_overflow on the next edge.
  - If a drop occurs on the same edge as a clear, the set wins and wr_overflow stays 1.
- Protocol rules:
  - wr_req_tgl never changes while in WAIT_ACK.
  - An ack_s change observed in IDLE (protocol error) is ignored and causes no state change.

Test Plan:
- Single event: reset, then wr_pulse for 1 cycle; bench receiver echoes req as ack after 3 cycles. Required: wr_req_tgl 0→1 one edge later, wr_busy=1, wr_sent one cycle at the expected edge, wr_pending stays 0, wr_overflow=0.
- Burst: 5 consecutive wr_pulse cycles with ack delay 6. Required: wr_pending reaches 4 and decrements on each launch; wr_req_tgl toggles 5 times in total; exactly 5 wr_sent pulses; final wr_req_tgl=1.
- Saturation (CNT_W=4, ack held): 20 pulses. Required: wr_pending saturates at 15, wr_overflow=1, and wr_overflow remains 1 through a later wr_clear_ovf asserted on a drop edge. It clears on the next edge only when no drop coincides with the clear.
- Simultaneous events: wr_pulse on the exact edge of a backlog launch with wr_pending=3. Required: wr_pending stays 3 on that edge and the toggle occurs.
- Reset mid-operation: wr_reset asserted during WAIT_ACK with wr_pending=2. Required: all outputs 0 on the next edge, and the next wr_pulse launches normally with wr_req_tgl 0→1.
- Spurious ack: toggle rd_ack_tgl while IDLE. Required: no wr_sent, no state change, wr_busy stays 0.
